// File: rtl/simon_sequence_gen.sv
// Pattern source for the Simon Says game: fills a DIFFICULTY-deep buffer of LED indices from a
// free-running LFSR on request and serves steps through a registered read port.
// Optional feature macro: SIMON_NO_REPEAT_EN (forces consecutive steps to differ).
//
// state | meaning
// IDLE  | no sequence captured since reset
// FILL  | writing one slot per clock from the LFSR
// READY | buffer holds a complete sequence
module simon_sequence_gen #(
   parameter int unsigned   DIFFICULTY = 6,
   parameter int unsigned   IDX_WIDTH  = 3,
   parameter logic [15:0]   SEED       = 16'hACE1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic                 i_New_Game,
   input  logic [IDX_WIDTH-1:0] i_Read_Idx,
   output logic [1:0]           o_Step,
   output logic                 o_Ready,
   output logic                 o_Busy
);

   localparam logic [IDX_WIDTH:0] LAST_SLOT = (IDX_WIDTH+1)'(DIFFICULTY - 1);
   localparam logic [15:0]        TAPS      = 16'hB400;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [15:0]        lfsr, lfsr_nxt;
   logic [IDX_WIDTH:0] count, count_nxt;
   logic [1:0]         buffer [DIFFICULTY];
   logic [1:0]         fill_val;
   logic [1:0]         read_val;
   logic               ready_nxt, busy_nxt;

   // A zero register would lock the Galois LFSR, so it is reloaded with SEED.
   always_comb begin
      lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
      if (lfsr == 16'h0000) begin
         lfsr_nxt = SEED;
      end
   end

`ifdef SIMON_NO_REPEAT_EN
   logic [1:0] prev_val;

   always_comb begin
      prev_val = 2'b00;
      for (int i = 1; i < int'(DIFFICULTY); i++) begin
         if (count == (IDX_WIDTH+1)'(i)) begin
            prev_val = buffer[i-1];
         end
      end
      fill_val = lfsr[1:0];
      if ((count != '0) && (lfsr[1:0] == prev_val)) begin
         fill_val = lfsr[1:0] + 2'd1;
      end
   end
`else
   always_comb begin
      fill_val = lfsr[1:0];
   end
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         IDLE, READY: begin
            if (i_New_Game) begin
               state_nxt = FILL;
               count_nxt = '0;
            end
         end
         FILL: begin
            count_nxt = count + (IDX_WIDTH+1)'(1);
            if (count == LAST_SLOT) begin
               state_nxt = READY;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
      ready_nxt = (state_nxt == READY);
      busy_nxt  = (state_nxt == FILL);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state   <= IDLE;
         count   <= '0;
         lfsr    <= SEED;
         o_Ready <= 1'b0;
         o_Busy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         lfsr    <= lfsr_nxt;
         o_Ready <= ready_nxt;
         o_Busy  <= busy_nxt;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         for (int i = 0; i < int'(DIFFICULTY); i++) begin
            buffer[i] <= 2'b00;
         end
      end else if (state == FILL) begin
         for (int i = 0; i < int'(DIFFICULTY); i++) begin
            if (count == (IDX_WIDTH+1)'(i)) begin
               buffer[i] <= fill_val;
            end
         end
      end
   end

   // Indices past the sequence end match no slot and read as zero.
   always_comb begin
      read_val = 2'b00;
      for (int i = 0; i < int'(DIFFICULTY); i++) begin
         if (i_Read_Idx == IDX_WIDTH'(i)) begin
            read_val = buffer[i];
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Step <= 2'b00;
      end else begin
         o_Step <= read_val;
      end
   end

endmodule

// File: tb/tb_simon_sequence_gen.sv
// Self-checking bench for simon_sequence_gen: a countdown-based fill model checked every cycle,
// plus directed reset, fill, restart, out-of-range and mid-fill reset scenarios.
module tb_simon_sequence_gen;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          DIFF = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       new_game = 1'b0;
   logic [2:0] read_idx = 3'd0;
   logic [1:0] step;
   logic       ready, busy;

   int checks = 0;
   int errors = 0;

   simon_sequence_gen #(.DIFFICULTY(DIFF), .IDX_WIDTH(3), .SEED(SEED)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_New_Game(new_game), .i_Read_Idx(read_idx),
      .o_Step(step), .o_Ready(ready), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: fill tracked as "slots still to write", not as FSM states.
   logic [15:0] m_lfsr;
   int          m_left;
   bit          m_ready;
   logic [1:0]  m_buf [DIFF];
   logic [1:0]  m_step;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      if (v == 16'h0000) return SEED;
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset();
      m_lfsr = SEED; m_left = 0; m_ready = 0; m_step = 2'b00;
      for (int i = 0; i < DIFF; i++) m_buf[i] = 2'b00;
   endtask

   task automatic model_step();
      int slot;
      logic [1:0] v;
      m_step = (int'(read_idx) < DIFF) ? m_buf[read_idx] : 2'b00;
      if (m_left > 0) begin
         slot = DIFF - m_left;
         v = m_lfsr[1:0];
`ifdef SIMON_NO_REPEAT_EN
         if (slot > 0 && v == m_buf[slot-1]) v = v + 2'd1;
`endif
         m_buf[slot] = v;
         m_left--;
         if (m_left == 0) m_ready = 1;
      end else if (new_game) begin
         m_left = DIFF;
         m_ready = 0;
      end
      m_lfsr = lfsr_adv(m_lfsr);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   always @(negedge clk) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("ready", int'(ready), int'(m_ready));
      chk("step", int'(step), int'(m_step));
      chk("ready_busy_exclusive", int'(ready & busy), 0);
   end

   task automatic read_slot(input int j, output logic [1:0] v);
      read_idx = 3'(j);
      @(negedge clk);
      v = step;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!ready) chk(name, 0, 1);
   endtask

   logic [1:0] v;
   logic [1:0] vals [DIFF];
   logic [1:0] pin_vals [DIFF];
   int n, repeats;

   initial begin
`ifdef SIMON_NO_REPEAT_EN
      pin_vals = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
`else
      pin_vals = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3};
`endif
      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(ready), 0);
      chk("reset_step", int'(step), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("lfsr_first", int'(dut.lfsr), int'(16'hE270));
      chk("model_lfsr_first", int'(m_lfsr), int'(16'hE270));
      for (int j = 0; j < DIFF; j++) begin
         read_slot(j, v);
         chk("reset_read", int'(v), 0);
      end

      // Plain fill
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      count_busy(n);
      chk("fill_busy_cycles", n, DIFF);
      chk("fill_ready", int'(ready), 1);
      for (int j = 0; j < DIFF; j++) begin
         read_slot(j, v);
         chk("fill_read", int'(v), int'(m_buf[j]));
      end

      // Out of range, one cycle after index change
      read_idx = 3'd6;
      @(negedge clk);
      chk("oor_6", int'(step), 0);
      read_idx = 3'd3;
      @(negedge clk);
      chk("idx3", int'(step), int'(m_buf[3]));
      read_idx = 3'd7;
      @(negedge clk);
      chk("oor_7", int'(step), 0);

      // Pulse in READY, second request during FILL is ignored
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      chk("restart_ready_drop", int'(ready), 0);
      chk("restart_busy", int'(busy), 1);
      @(negedge clk);
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      n = 3;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("restart_latency", n, DIFF);
      @(negedge clk);
      chk("restart_stays_ready", int'(ready), 1);

      // Asynchronous reset mid-fill
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      chk("midfill_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midfill_busy", int'(busy), 0);
      chk("midfill_ready", int'(ready), 0);
      chk("midfill_lfsr", int'(dut.lfsr), int'(SEED));
      @(negedge clk);
      rst = 1'b0;
      new_game = 1'b1;
      read_idx = 3'd0;
      @(negedge clk);
      new_game = 1'b0;
      chk("pin_lfsr", int'(dut.lfsr), int'(16'hE270));
      count_busy(n);
      chk("pin_busy_cycles", n, DIFF);
      chk("pin_ready", int'(ready), 1);
      for (int j = 0; j < DIFF; j++) begin
         chk("pin_model", int'(m_buf[j]), int'(pin_vals[j]));
         read_slot(j, v);
         chk("pin_read", int'(v), int'(pin_vals[j]));
      end

      // Many fills: consecutive-repeat behaviour
      repeats = 0;
      for (int f = 0; f < 1000; f++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         new_game = 1'b1;
         @(negedge clk);
         new_game = 1'b0;
         wait_ready("fill_timeout");
         for (int j = 0; j < DIFF; j++) begin
            read_slot(j, v);
            vals[j] = v;
         end
         for (int j = 1; j < DIFF; j++) begin
            if (vals[j] == vals[j-1]) repeats++;
         end
`ifdef SIMON_NO_REPEAT_EN
         chk("no_repeat", repeats, 0);
`endif
      end
`ifndef SIMON_NO_REPEAT_EN
      chk("repeat_seen", int'(repeats > 0), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
